// File: rtl/vga_digit_display.sv
// VGA 640x480 timing plus NDIG coloured seven-segment digits drawn from frame-latched inputs.
// One-cycle registered output latency; free-running, no backpressure.
module vga_digit_display #(
  parameter int HPIXELS      = 800,
  parameter int VLINES       = 521,
  parameter int HPULSE       = 96,
  parameter int VPULSE       = 2,
  parameter int HBP          = 144,
  parameter int HFP          = 784,
  parameter int VBP          = 31,
  parameter int VFP          = 511,
  parameter int NDIG         = 6,
  parameter int DIG_W        = 80,
  parameter int DIG_H        = 165,
  parameter int SEG_T        = 5,
  parameter int X0           = 0,
  parameter int Y0           = 255,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                dclk,
  input  logic                clr,
  input  logic [4*NDIG-1:0]   digits,
  input  logic [NDIG-1:0]     blank_mask,
  input  logic [NDIG-1:0]     blink_mask,
  output logic                hsync,
  output logic                vsync,
  output logic [2:0]          red,
  output logic [2:0]          green,
  output logic [1:0]          blue,
  output logic                frame_start
);

  localparam int HW = $clog2(HPIXELS);
  localparam int VW = $clog2(VLINES);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int M  = (DIG_H - SEG_T) / 2;

  if (X0 + NDIG * DIG_W > HFP - HBP || Y0 + DIG_H > VFP - VBP) begin : g_bad_geometry
    $error("digit block does not fit inside the active area");
  end

  logic [HW-1:0]     hc;
  logic [VW-1:0]     vc;
  logic [FW-1:0]     fcnt;
  logic              blink_phase;
  logic [4*NDIG-1:0] sh_digits;
  logic [NDIG-1:0]   sh_blank;
  logic [NDIG-1:0]   sh_blink;
  logic [7:0]        rgb_n;

  // Bit order {g,f,e,d,c,b,a}; codes above 9 show a dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [6:0] seg_region(input int x, input int y);
    logic [6:0] r;
    r[0] = (y < SEG_T);
    r[1] = (x >= DIG_W - SEG_T) && (y >= SEG_T) && (y < M);
    r[2] = (x >= DIG_W - SEG_T) && (y >= M + SEG_T) && (y < DIG_H - SEG_T);
    r[3] = (y >= DIG_H - SEG_T);
    r[4] = (x < SEG_T) && (y >= M + SEG_T) && (y < DIG_H - SEG_T);
    r[5] = (x < SEG_T) && (y >= SEG_T) && (y < M);
    r[6] = (y >= M) && (y < M + SEG_T);
    return r;
  endfunction

  function automatic logic [7:0] colour(input int idx);
    case (idx % 6)
      0:       return 8'b111_111_11;
      1:       return 8'b111_111_00;
      2:       return 8'b000_111_11;
      3:       return 8'b000_111_00;
      4:       return 8'b111_000_11;
      default: return 8'b111_000_00;
    endcase
  endfunction

  always_comb begin : render
    int lx;
    int ly;
    int hci;
    int vci;
    rgb_n = '0;
    hci   = int'(hc);
    vci   = int'(vc);
    ly    = vci - VBP - Y0;
    lx    = 0;
    for (int i = 0; i < NDIG; i++) begin
      lx = hci - HBP - X0 - i * DIG_W;
      if (lx >= 0 && lx < DIG_W && ly >= 0 && ly < DIG_H &&
          !sh_blank[i] && !(sh_blink[i] && blink_phase) &&
          |(seg_region(lx, ly) & seg_pattern(sh_digits[4*i +: 4])))
        rgb_n = rgb_n | colour(i);
    end
    if (!(hci >= HBP && hci < HFP && vci >= VBP && vci < VFP))
      rgb_n = '0;
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      sh_digits   <= '0;
      sh_blank    <= '1;
      sh_blink    <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (hc >= HW'(HPULSE));
      vsync       <= (vc >= VW'(VPULSE));
      frame_start <= (hc == '0) && (vc == '0);
      red         <= rgb_n[7:5];
      green       <= rgb_n[4:2];
      blue        <= rgb_n[1:0];
      if (hc == HW'(HPIXELS - 1)) begin
        hc <= '0;
        if (vc == VW'(VLINES - 1)) begin
          vc <= '0;
          // Latch inputs only between frames so a frame never tears.
          sh_digits <= digits;
          sh_blank  <= blank_mask;
          sh_blink  <= blink_mask;
          if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt        <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end else begin
          vc <= vc + VW'(1);
        end
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

endmodule

// File: doc/vga_digit_display.md
VGA_DIGIT_DISPLAY -- requirements
Module: vga_digit_display

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- HPIXELS, 800, pixels per line
- VLINES, 521, lines per frame
- HPULSE, 96, hsync pulse length
- VPULSE, 2, vsync pulse length
- HBP, 144, first active column
- HFP, 784, first front-porch column
- VBP, 31, first active line
- VFP, 511, first front-porch line
- NDIG, 6, digit count
- DIG_W, 80, digit cell width
- DIG_H, 165, digit height
- SEG_T, 5, stroke thickness
- X0, 0, left edge of digit 0, relative to HBP
- Y0, 255, top edge of the digits, relative to VBP
- BLINK_FRAMES, 30, frames per blink phase
REQ-002 Ports SHALL be (name, direction, width, meaning):
- dclk, in, 1, 25 MHz pixel clock
- clr, in, 1, reset; one clock, reset is synchronous and active-high
- digits, in, 4*NDIG, BCD code per digit; digit i = bits [4i+3:4i], digit 0 leftmost
- blank_mask, in, NDIG, 1 = digit i dark
- blink_mask, in, NDIG, 1 = digit i blinks
- hsync, out, 1, active-low horizontal sync
- vsync, out, 1, active-low vertical sync
- red, out, 3, red level
- green, out, 3, green level
- blue, out, 2, blue level
- frame_start, out, 1, one-cycle pulse at the first pixel of each frame
REQ-003 Elaboration SHALL fail if X0+NDIG*DIG_W > HFP-HBP or Y0+DIG_H > VFP-VBP.

Function
REQ-004 hc SHALL count 0..HPIXELS-1 every dclk and wrap to 0; vc SHALL increment at each hc wrap and wrap from VLINES-1 to 0.
REQ-005 All outputs SHALL be registered and aligned, so the output in cycle n+1 reflects counter position (hc,vc) from cycle n; latency is 1 cycle.
REQ-006 hsync SHALL be 0 for hc<HPULSE and 1 otherwise; vsync SHALL be 0 for vc<VPULSE and 1 otherwise.
REQ-007 frame_start SHALL be 1 exactly when the outputs correspond to hc=0, vc=0.
REQ-008 At the clock edge where hc=HPIXELS-1 and vc=VLINES-1, digits, blank_mask and blink_mask SHALL be captured into shadow registers; rendering SHALL use only the shadow values, so input changes mid-frame never tear.
REQ-009 A frame counter SHALL count 0..BLINK_FRAMES-1 on the same edge as the shadow capture; on wrap, blink_phase SHALL toggle.
REQ-010 Digit i's cell SHALL span local x = hc-HBP-X0-i*DIG_W in [0,DIG_W) and local y = vc-VBP-Y0 in [0,DIG_H).
REQ-011 Segments SHALL be defined with M=(DIG_H-SEG_T)/2 (integer division):
- a: y<SEG_T
- f: x<SEG_T, SEG_T<=y<M
- b: x>=DIG_W-SEG_T, SEG_T<=y<M
- g: M<=y<M+SEG_T
- e: x<SEG_T, M+SEG_T<=y<DIG_H-SEG_T
- c: x>=DIG_W-SEG_T, M+SEG_T<=y<DIG_H-SEG_T
- d: y>=DIG_H-SEG_T
REQ-012 Codes 0-9 SHALL light the standard seven-segment patterns; codes 10-15 SHALL light only g.
REQ-013 A pixel SHALL be lit when it lies in a lit segment of digit i, shadow blank bit i = 0, and NOT (shadow blink bit i = 1 AND blink_phase = 1).
REQ-014 A lit pixel SHALL take colour index i mod 6 as {red,green,blue}:
- 0 = 111,111,11
- 1 = 111,111,00
- 2 = 000,111,11
- 3 = 000,111,00
- 4 = 111,000,11
- 5 = 111,000,00
REQ-015 All other pixels, including every pixel outside HBP<=hc<HFP and VBP<=vc<VFP, SHALL output rgb = 0.

Reset
REQ-016 While clr=1 at a dclk edge, the block SHALL set hc=vc=0, frame counter=0, blink_phase=0, shadow digits=0, shadow blank_mask=all 1s, shadow blink_mask=0.
REQ-017 While clr=1 at a dclk edge, the block SHALL set hsync=0, vsync=0, rgb=0 and frame_start=0.
REQ-018 Reset mid-frame SHALL abandon the frame; the first cycle after clr falls SHALL process position (0,0), and frame_start SHALL assert on the following cycle.

Verification
REQ-019 Sync timing: release reset -> hsync period 800 cycles, low for 96; vsync low for 2 lines of every 521; frame_start every 416800 cycles.
REQ-020 Digit "8" at digit 0, masks 0 -> pixel (hc=144,vc=286) white; (hc=184,vc=300) black; all seven segments lit.
REQ-021 digits changed while vc=300 -> current frame unchanged; new value visible from the next frame.
REQ-022 Code 4'hC on digit 2 -> only the g band, vc 366..370, is lit cyan at hc 304..383.
REQ-023 blink_mask bit 1 set -> digit 1 visible for 30 frames, dark for 30, repeating; blank_mask bit 1 set -> always dark.
REQ-024 clr asserted at hc=400, vc=200 -> the next cycle shows hsync=vsync=0 and rgb=0, and frame_start pulses 2 cycles after clr falls.
